// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-latency video fetch with absolute priority,
// CPU req/ack accesses slotted into cycles the video path leaves free.
//   state | meaning
//   IDLE  | no CPU access outstanding
//   PEND  | CPU request waiting for a free RAM cycle
//   WR    | CPU write on the RAM port
//   RD1   | CPU read address on the RAM port
//   RD2   | CPU read data returning from RAM
//   ACK   | one-cycle completion pulse
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DEPTH        = 7168,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              CLK_25MHZ,
    input  logic              RESET,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic [7:0]        VID_DATA,
    output logic              VID_VALID,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [7:0]        CPU_WDATA,
    output logic [7:0]        CPU_RDATA,
    output logic              CPU_ACK,
    output logic              CPU_STARVED,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [7:0]        RAM_WDATA,
    input  logic [7:0]        RAM_RDATA
);

    typedef enum logic [2:0] {IDLE, PEND, WR, RD1, RD2, ACK} cpu_state_t;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

    cpu_state_t       state, state_nxt;
    logic             cpu_win;
    logic             vid_in_range, cpu_in_range;
    logic             vid_p1, vid_p2, vid_oor_p1, vid_oor_p2;
    logic             cpu_oor_q;
    logic [CNT_W-1:0] wait_cnt;

    assign vid_in_range = {1'b0, VID_ADDR} < DEPTH_L;
    assign cpu_in_range = {1'b0, CPU_ADDR} < DEPTH_L;

    // A request seen in IDLE competes in that same cycle, so IDLE and PEND share arbitration.
    always_comb begin
        state_nxt = state;
        cpu_win   = 1'b0;
        case (state)
            IDLE, PEND: begin
                if (!CPU_REQ) begin
                    state_nxt = IDLE;
                end else if (VID_REQ) begin
                    state_nxt = PEND;
                end else begin
                    cpu_win   = 1'b1;
                    state_nxt = CPU_WE ? WR : RD1;
                end
            end
            WR:      state_nxt = ACK;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            RAM_ADDR   <= '0;
            RAM_WE     <= 1'b0;
            RAM_WDATA  <= '0;
            cpu_oor_q  <= 1'b0;
            vid_p1     <= 1'b0;
            vid_p2     <= 1'b0;
            vid_oor_p1 <= 1'b0;
            vid_oor_p2 <= 1'b0;
            VID_VALID  <= 1'b0;
            VID_DATA   <= '0;
            CPU_RDATA  <= '0;
        end else begin
            state <= state_nxt;

            if (state == PEND && state_nxt == PEND) begin
                if (wait_cnt != CNT_MAX)
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (VID_REQ) begin
                RAM_ADDR <= VID_ADDR;
                RAM_WE   <= 1'b0;
            end else if (cpu_win) begin
                RAM_ADDR  <= CPU_ADDR;
                RAM_WE    <= CPU_WE & cpu_in_range;
                RAM_WDATA <= CPU_WDATA;
            end else begin
                RAM_WE <= 1'b0;
            end

            if (cpu_win)
                cpu_oor_q <= !cpu_in_range;

            // Video pipe: address on RAM, data back from RAM, registered output.
            vid_p1     <= VID_REQ;
            vid_oor_p1 <= !vid_in_range;
            vid_p2     <= vid_p1;
            vid_oor_p2 <= vid_oor_p1;
            VID_VALID  <= vid_p2;
            if (vid_p2)
                VID_DATA <= vid_oor_p2 ? 8'h00 : RAM_RDATA;

            if (state == RD2)
                CPU_RDATA <= cpu_oor_q ? 8'h00 : RAM_RDATA;
        end
    end

    assign CPU_ACK     = (state == ACK);
    assign CPU_STARVED = (wait_cnt >= CNT_MAX);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model plus a cycle-slot reference model that
// schedules expected outputs from the arbitration rules and fixed latencies.
module tb_vram_arbiter;

    localparam int ADDR_W       = 13;
    localparam int DEPTH        = 7168;
    localparam int STARVE_LIMIT = 64;
    localparam int MAXC         = 8192;

    typedef struct packed {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        VID_REQ = 1'b0;
    logic [12:0] VID_ADDR = '0;
    logic [7:0]  VID_DATA;
    logic        VID_VALID;
    logic        CPU_REQ = 1'b0;
    logic        CPU_WE = 1'b0;
    logic [12:0] CPU_ADDR = '0;
    logic [7:0]  CPU_WDATA = '0;
    logic [7:0]  CPU_RDATA;
    logic        CPU_ACK;
    logic        CPU_STARVED;
    logic [12:0] RAM_ADDR;
    logic        RAM_WE;
    logic [7:0]  RAM_WDATA;
    logic [7:0]  ram_rdata;

    always #20 clk = ~clk;

    vram_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK_25MHZ(clk), .RESET(RESET),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_DATA(VID_DATA), .VID_VALID(VID_VALID),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK), .CPU_STARVED(CPU_STARVED),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA), .RAM_RDATA(ram_rdata)
    );

    function automatic logic [7:0] init_byte(input int a);
        if (a == 16) return 8'hA5;
        return 8'(a * 37 + (a >> 5) + 90);
    endfunction

    // Synchronous single-port RAM, one-cycle read latency; full 8K so stray addresses are visible.
    logic [7:0] mem [0:8191];
    logic       preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_byte(i);
        end else begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
            ram_rdata <= mem[RAM_ADDR];
        end
    end

    // Reference model state: expectations filed by cycle number.
    logic [7:0]  ref_mem [0:8191];
    bit          exp_vv [MAXC];
    bit          exp_ack [MAXC];
    bit          exp_rd_upd [MAXC];
    bit          exp_addr_upd [MAXC];
    bit          exp_we [MAXC];
    bit          exp_zero [MAXC];
    logic [7:0]  exp_vd [MAXC];
    logic [7:0]  exp_rd [MAXC];
    logic [7:0]  exp_wd [MAXC];
    logic [12:0] exp_addr [MAXC];
    logic [7:0]  cur_vd, cur_rd;
    logic [12:0] cur_addr;
    int          lose_run, cpu_free_at, cyc;
    int          checks, errors;
    txn_t        cpu_q [$];
    bit          drop_en, rel_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_checks();
        if (exp_zero[cyc]) begin
            cur_vd   = 8'h00;
            cur_rd   = 8'h00;
            cur_addr = '0;
            chk("ram_wdata_rst", RAM_WDATA, 0);
        end
        if (exp_vv[cyc])       cur_vd   = exp_vd[cyc];
        if (exp_rd_upd[cyc])   cur_rd   = exp_rd[cyc];
        if (exp_addr_upd[cyc]) cur_addr = exp_addr[cyc];
        chk("vid_valid", VID_VALID, exp_vv[cyc]);
        chk("vid_data", VID_DATA, cur_vd);
        chk("cpu_ack", CPU_ACK, exp_ack[cyc]);
        chk("cpu_rdata", CPU_RDATA, cur_rd);
        chk("ram_addr", RAM_ADDR, cur_addr);
        chk("ram_we", RAM_WE, exp_we[cyc]);
        if (exp_we[cyc]) chk("ram_wdata", RAM_WDATA, exp_wd[cyc]);
        chk("cpu_starved", CPU_STARVED, lose_run > STARVE_LIMIT);
    endtask

    // One cycle of arbitration rules: video always wins; CPU takes a free cycle
    // and completes 2 (write) or 3 (read) cycles later; reset drops everything in flight.
    task automatic model_cycle(input bit rst, input bit vreq, input logic [12:0] vaddr,
                               input bit creq, input bit cwe, input logic [12:0] caddr,
                               input logic [7:0] cwd, output bit won);
        won = 1'b0;
        if (rst) begin
            for (int k = 1; k <= 4; k++) begin
                exp_vv[cyc+k] = 0; exp_ack[cyc+k] = 0; exp_rd_upd[cyc+k] = 0;
                exp_addr_upd[cyc+k] = 0; exp_we[cyc+k] = 0; exp_zero[cyc+k] = 0;
            end
            exp_zero[cyc+1] = 1;
            lose_run    = 0;
            cpu_free_at = cyc + 1;
            return;
        end
        if (vreq) begin
            exp_vv[cyc+3]       = 1;
            exp_vd[cyc+3]       = (int'(vaddr) < DEPTH) ? ref_mem[vaddr] : 8'h00;
            exp_addr_upd[cyc+1] = 1;
            exp_addr[cyc+1]     = vaddr;
        end
        if (cyc >= cpu_free_at && creq) begin
            if (vreq) begin
                lose_run++;
            end else begin
                won = 1'b1;
                lose_run = 0;
                exp_addr_upd[cyc+1] = 1;
                exp_addr[cyc+1]     = caddr;
                if (cwe) begin
                    if (int'(caddr) < DEPTH) begin
                        exp_we[cyc+1] = 1;
                        exp_wd[cyc+1] = cwd;
                        ref_mem[caddr] = cwd;
                    end
                    exp_ack[cyc+2] = 1;
                    cpu_free_at = cyc + 3;
                end else begin
                    exp_ack[cyc+3]    = 1;
                    exp_rd_upd[cyc+3] = 1;
                    exp_rd[cyc+3]     = (int'(caddr) < DEPTH) ? ref_mem[caddr] : 8'h00;
                    cpu_free_at = cyc + 4;
                end
            end
        end else begin
            lose_run = 0;
        end
    endtask

    task automatic step(input bit rst, input bit vreq, input logic [12:0] vaddr);
        bit won;
        @(negedge clk);
        do_checks();
        if (rst) begin
            CPU_REQ = 1'b0;
        end else if (cyc < cpu_free_at) begin
            if (rel_en && $urandom_range(0, 3) == 0) CPU_REQ = 1'b0;
        end else if (cpu_q.size() != 0) begin
            if (drop_en && CPU_REQ && $urandom_range(0, 5) == 0) begin
                CPU_REQ = 1'b0;
            end else begin
                CPU_REQ   = 1'b1;
                CPU_WE    = cpu_q[0].we;
                CPU_ADDR  = cpu_q[0].addr;
                CPU_WDATA = cpu_q[0].data;
            end
        end else begin
            CPU_REQ = 1'b0;
        end
        RESET    = rst;
        VID_REQ  = vreq;
        VID_ADDR = vaddr;
        model_cycle(rst, vreq, vaddr, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, won);
        if (won) void'(cpu_q.pop_front());
        cyc++;
    endtask

    function automatic logic [12:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 13'($urandom_range(DEPTH, 8191));
        return 13'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        txn_t t;
        int   vprob;
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(i);
        checks = 0; errors = 0; lose_run = 0; cpu_free_at = 0;
        drop_en = 0; rel_en = 0;
        @(posedge clk);
        #1 preload = 1'b0;
        cyc = 0;
        exp_zero[0] = 1;

        // Reset, then a single fetch of the 0xA5 byte.
        repeat (3) step(1, 0, '0);
        step(0, 1, 13'h0010);
        repeat (5) step(0, 0, '0);

        // Uncontended write then read back.
        t = '{we: 1'b1, addr: 13'h0100, data: 8'h3C}; cpu_q.push_back(t);
        t = '{we: 1'b0, addr: 13'h0100, data: 8'h00}; cpu_q.push_back(t);
        repeat (10) step(0, 0, '0);

        // CPU pending under 10 back-to-back fetches.
        t = '{we: 1'b1, addr: 13'h0222, data: 8'h6B}; cpu_q.push_back(t);
        for (int i = 0; i < 10; i++) step(0, 1, 13'(13'h0200 + i));
        repeat (6) step(0, 0, '0);

        // Starvation flag across a 70-cycle fetch burst.
        t = '{we: 1'b0, addr: 13'h0222, data: 8'h00}; cpu_q.push_back(t);
        for (int i = 0; i < 70; i++) step(0, 1, 13'(13'h0400 + i));
        repeat (6) step(0, 0, '0);

        // Out-of-range accesses.
        t = '{we: 1'b1, addr: 13'd7168, data: 8'h55}; cpu_q.push_back(t);
        t = '{we: 1'b0, addr: 13'd7200, data: 8'h00}; cpu_q.push_back(t);
        repeat (8) step(0, 0, '0);
        step(0, 1, 13'd7168);
        repeat (4) step(0, 0, '0);

        // Reset during RD1 with fetches in flight, then a clean access.
        step(0, 1, 13'h0030);
        t = '{we: 1'b0, addr: 13'h0040, data: 8'h00}; cpu_q.push_back(t);
        step(0, 0, '0);
        step(1, 1, 13'h0050);
        step(0, 0, '0);
        t = '{we: 1'b0, addr: 13'h0100, data: 8'h00}; cpu_q.push_back(t);
        repeat (8) step(0, 0, '0);

        // Random traffic with request drops, early releases and occasional resets.
        drop_en = 1; rel_en = 1; vprob = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: vprob = 0;
                    1: vprob = 30;
                    2: vprob = 60;
                    default: vprob = 95;
                endcase
            end
            if (cpu_q.size() < 2 && $urandom_range(0, 3) == 0) begin
                t.we   = 1'($urandom_range(0, 1));
                t.addr = rnd_addr();
                t.data = 8'($urandom_range(0, 255));
                cpu_q.push_back(t);
            end
            step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < vprob, rnd_addr());
        end
        drop_en = 0; rel_en = 0;
        repeat (12) step(0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: VGA scanout fetch (video) and the game CPU bus (cpu).
- Video fetches have fixed latency and absolute priority, so scanout never stalls. CPU accesses use a req/ack handshake and are slotted into free cycles.
- Sits inside topEntity on the 25 MHz pixel clock, between the video timing/pixel fetch logic, the CPU memory map and the VRAM instance.

Parameters:
- ADDR_W, 13, width of all address ports
- DEPTH, 7168, number of implemented bytes; valid addresses are 0..DEPTH-1
- STARVE_LIMIT, 64, CPU wait-cycle count at which CPU_STARVED asserts

Ports:
- CLK_25MHZ  in  1  pixel clock; the only clock
- RESET  in  1  synchronous, active-high reset
- VID_REQ  in  1  one-cycle fetch strobe; may be high on consecutive cycles
- VID_ADDR  in  ADDR_W  fetch address, sampled with VID_REQ
- VID_DATA  out  8  fetched byte
- VID_VALID  out  1  VID_DATA valid this cycle
- CPU_REQ  in  1  access request level, held until CPU_ACK
- CPU_WE  in  1  1=write, 0=read; sampled at issue
- CPU_ADDR  in  ADDR_W  CPU address
- CPU_WDATA  in  8  write data
- CPU_RDATA  out  8  read data, valid when CPU_ACK is high for a read
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_STARVED  out  1  CPU has waited at least STARVE_LIMIT cycles
- RAM_ADDR  out  ADDR_W  RAM address (registered)
- RAM_WE  out  1  RAM write enable (registered)
- RAM_WDATA  out  8  RAM write data (registered)
- RAM_RDATA  in  8  RAM read data; valid 1 cycle after address is presented

Behaviour:
- Clock and reset: one clock, CLK_25MHZ. Reset is synchronous and active-high on RESET.
- Reset values: all outputs are 0. The CPU FSM goes to IDLE, the video valid pipe clears, and the wait counter clears.
- Reset mid-operation: any in-flight access is discarded. No ACK and no VALID are produced for it.
- Arbitration, decided each cycle N:
  - If VID_REQ=1, video wins.
  - Otherwise, if the CPU FSM is in PEND, the CPU wins.
  - Otherwise the RAM is idle: RAM_WE=0 and RAM_ADDR holds its last value.
- Winner's signals appear on RAM_ADDR/RAM_WE/RAM_WDATA in cycle N+1.
- Video path:
  - Video read issued at N: RAM_WE=0 in N+1.
  - RAM_RDATA is valid in N+2 and is registered.
  - VID_DATA and VID_VALID=1 appear in N+3. Fixed latency is 3 and fully pipelined.
  - VID_VALID is 0 when no fetch completes that cycle. VID_DATA holds its last value.
  - If VID_ADDR >= DEPTH: RAM_ADDR is still driven, but VID_DATA=0.
- CPU FSM states: IDLE, PEND, WR, RD1, RD2, ACK.
  - IDLE: CPU_REQ=1 -> PEND. The request is eligible for arbitration in the same cycle.
  - PEND: lost arbitration -> stay in PEND. Won as a write -> WR. Won as a read -> RD1. CPU_REQ dropped before winning -> IDLE, with no ACK.
  - WR: RAM_WE=1 this cycle -> ACK.
  - RD1: address on RAM this cycle -> RD2.
  - RD2: RAM_RDATA is registered into CPU_RDATA -> ACK.
  - ACK: CPU_ACK=1 for exactly one cycle -> IDLE. CPU_REQ is ignored in this cycle.
- CPU timing:
  - Uncontended write sampled at M: ACK at M+2.
  - Uncontended read sampled at M: ACK at M+3.
  - Once issued, an access always completes with ACK, even if CPU_REQ drops.
- CPU out-of-range addresses (CPU_ADDR >= DEPTH):
  - Write: RAM_WE stays 0, but the FSM still passes through WR and ACK.
  - Read: returns CPU_RDATA=0.
- CPU_RDATA holds its value until the next read completes.
- CPU_STARVED:
  - A saturating wait counter increments on every cycle spent in PEND and clears when the FSM leaves PEND.
  - CPU_STARVED = (counter >= STARVE_LIMIT). It is a status output only and does not change arbitration.
- Back-to-back video requests every cycle block the CPU indefinitely. This is by design: blanking intervals provide the gaps.

Test Plan:
- Reset, then a single VID_REQ with VID_ADDR=0x0010, RAM preloaded 0xA5 -> VID_VALID=1 with VID_DATA=0xA5 exactly 3 cycles later; all outputs 0 during reset.
- Uncontended CPU write 0x3C to 0x0100, then a read of 0x0100 -> write ACK at +2 with RAM_WE=1 for one cycle; read ACK at +3 with CPU_RDATA=0x3C.
- CPU_REQ held while VID_REQ is high for 10 consecutive cycles -> CPU stays in PEND; 10 VID_VALID pulses with the correct data; CPU issues on the first cycle without VID_REQ; no collision on RAM_WE.
- VID_REQ held 70 cycles with CPU pending, STARVE_LIMIT=64 -> CPU_STARVED rises after 64 wait cycles and clears once the CPU issues.
- CPU write to address 7168 and read of 7200 -> RAM_WE never asserts; both ACK; read returns 0. VID_ADDR=7168 -> VID_DATA=0.
- RESET asserted in the RD1 cycle, plus two video fetches in flight -> no CPU_ACK and no VID_VALID afterwards; FSM in IDLE; a new request then completes normally.
